// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive message controller
package uart_pkg;

  localparam int DATA_W = 8;
  localparam int MSG_W  = 32;
  localparam logic [7:0] ERRCNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    ERR  = 2'd2
  } state_t;

endpackage

// File: rtl/uart_rx_msg_controller_if.sv
// rtl/uart_rx_msg_controller_if.sv - receiver flags in, assembled message and status out
interface uart_rx_msg_controller_if;
  import uart_pkg::*;

  logic              enable;
  logic              Rx_VALID;
  logic              Rx_PERROR;
  logic              Rx_FERROR;
  logic [DATA_W-1:0] Rx_DATA;
  logic              Rx_EN;
  logic [MSG_W-1:0]  msg_data;
  logic              msg_ready;
  logic              busy;
  logic              timeout_err;
  logic [7:0]        err_count;

  modport master (
    output enable, Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA,
    input  Rx_EN, msg_data, msg_ready, busy, timeout_err, err_count
  );

  modport slave (
    input  enable, Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA,
    output Rx_EN, msg_data, msg_ready, busy, timeout_err, err_count
  );

endinterface

// File: rtl/rx_flag_edge_detect.sv
// rtl/rx_flag_edge_detect.sv - registered rising-edge detector for the receiver flags
module rx_flag_edge_detect (
  input  logic       Clk,
  input  logic       reset,
  input  logic [2:0] flags,
  output logic [2:0] rise
);

  logic [2:0] prev_q;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) prev_q <= '0;
    else        prev_q <= flags;
  end

  assign rise = flags & ~prev_q;

endmodule

// File: rtl/uart_rx_msg_controller.sv
// rtl/uart_rx_msg_controller.sv - assembles MSG_BYTES good receiver bytes into a message word
module uart_rx_msg_controller
  import uart_pkg::*;
#(
  parameter int MSG_BYTES      = 4,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int CNT_W          = 18
) (
  input logic Clk,
  input logic reset,
  uart_rx_msg_controller_if.slave bus
);

  localparam logic [1:0]       LAST_IDX = 2'(MSG_BYTES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [MSG_W-1:0]  asm_q, asm_d;
  logic [MSG_W-1:0]  msg_data_q, msg_data_d;
  logic              msg_ready_q, msg_ready_d;
  logic              timeout_q, timeout_d;
  logic [7:0]        err_q, err_d;
  logic [MSG_W-1:0]  word;
  logic [2:0]        rise;
  logic              v_evt, e_evt, flags_clear;

  rx_flag_edge_detect u_edge (
    .Clk   (Clk),
    .reset (reset),
    .flags ({bus.Rx_FERROR, bus.Rx_PERROR, bus.Rx_VALID}),
    .rise  (rise)
  );

  assign v_evt       = rise[0];
  assign e_evt       = rise[1] | rise[2];
  assign flags_clear = !bus.Rx_PERROR && !bus.Rx_FERROR;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      byte_idx_q  <= '0;
      timer_q     <= '0;
      asm_q       <= '0;
      msg_data_q  <= '0;
      msg_ready_q <= 1'b0;
      timeout_q   <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      timer_q     <= timer_d;
      asm_q       <= asm_d;
      msg_data_q  <= msg_data_d;
      msg_ready_q <= msg_ready_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    timer_d     = timer_q;
    asm_d       = asm_q;
    msg_data_d  = msg_data_q;
    msg_ready_d = 1'b0;
    timeout_d   = 1'b0;
    err_d       = err_q;

    // The first byte starts from a cleared word so unused low slots stay zero.
    word = (byte_idx_q == 2'd0) ? '0 : asm_q;
    for (int i = 0; i < 4; i++) begin
      if (byte_idx_q == 2'(i)) word[MSG_W-1-DATA_W*i -: DATA_W] = bus.Rx_DATA;
    end

    case (state_q)
      IDLE: begin
        if (bus.enable) state_d = RECV;
      end
      RECV: begin
        if (e_evt) begin
          byte_idx_d = '0;
          timer_d    = '0;
          if (err_q != ERRCNT_MAX) err_d = err_q + 8'd1;
          state_d    = ERR;
        end else if (v_evt && flags_clear) begin
          asm_d   = word;
          timer_d = '0;
          if (byte_idx_q == LAST_IDX) begin
            msg_data_d  = word;
            msg_ready_d = 1'b1;
            byte_idx_d  = '0;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end else if (byte_idx_q != 2'd0) begin
          // Fire on the edge where the timer would reach its last count.
          if ((timer_q + 1'b1) == TMO_LAST) begin
            timeout_d  = 1'b1;
            byte_idx_d = '0;
            timer_d    = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        if (!bus.enable) begin
          state_d    = IDLE;
          byte_idx_d = '0;
          timer_d    = '0;
        end
      end
      ERR: begin
        if (flags_clear) state_d = RECV;
        if (!bus.enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.Rx_EN       = (state_q != IDLE);
  assign bus.msg_data    = msg_data_q;
  assign bus.msg_ready   = msg_ready_q;
  assign bus.busy        = (byte_idx_q != 2'd0);
  assign bus.timeout_err = timeout_q;
  assign bus.err_count   = err_q;

endmodule
